// File: rtl/pe_irq_ctrl_pkg.sv
// pe_irq_ctrl_pkg: shared types, register map and helpers for the PE
// interrupt controller.
//   word_t            32-bit bus word
//   IRQC_BASE         base of the controller's internal region
//   IRQC_STATUS..     byte offsets of the six registers
//   irqc_sat_inc      saturating 32-bit increment
//   irqc_claim_code   lowest-index active source + 1, or 0 when none
package pe_irq_ctrl_pkg;

  typedef logic [31:0] word_t;

  localparam word_t IRQC_BASE    = 32'hF000_0000;
  localparam word_t IRQC_STATUS  = 32'h0000_0000;
  localparam word_t IRQC_PENDING = 32'h0000_0004;
  localparam word_t IRQC_MASK    = 32'h0000_0008;
  localparam word_t IRQC_EDGE    = 32'h0000_000C;
  localparam word_t IRQC_CLAIM   = 32'h0000_0010;
  localparam word_t IRQC_LATENCY = 32'h0000_0014;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic word_t irqc_sat_inc(input word_t value);
    word_t result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  // Scan from the top so the lowest set index is the last one written.
  function automatic logic [3:0] irqc_claim_code(input logic [7:0] status);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (status[i]) begin
        code = 4'(i + 1);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/pe_irq_ctrl_source.sv
// pe_irq_source: one interrupt source cell (irq_prev + pending flop).
//   clock      rising-edge clock
//   reset      synchronous, active-low
//   irq        raw interrupt line
//   edge_mode  1 = rising-edge latched, 0 = level (pending follows irq)
//   clear      clear request (W1C or claim); ignored in level mode
//   pending    registered pending flag
module pe_irq_source (
  input  logic clock,
  input  logic reset,
  input  logic irq,
  input  logic edge_mode,
  input  logic clear,
  output logic pending
);

  logic irq_prev_r;
  logic pending_r;
  logic rise_s;
  logic pending_next_s;

  // Next pending value: a rising edge beats a same-cycle clear.
  always_comb begin
    rise_s = irq & ~irq_prev_r;
    if (edge_mode) begin
      pending_next_s = rise_s | (pending_r & ~clear);
    end else begin
      pending_next_s = irq;
    end
  end

  // Source history and pending state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_prev_r <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      irq_prev_r <= irq;
      pending_r  <= pending_next_s;
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/pe_irq_ctrl.sv
// pe_irq_ctrl: memory-mapped interrupt controller for one manycore PE.
// Latches raw sources, masks and prioritises them (lowest index wins),
// drives the CPU external interrupt vector and measures claim latency.
//   clock     rising-edge clock
//   reset     synchronous, active-low
//   irq_in    raw sources (0 periph, 1 ddma send, 2 recv size, 3 recv hs)
//   sel_in    access targets this block
//   addr_in   byte address, bits [4:2] decoded
//   wr_in     write strobe
//   data_in   write data
//   data_out  registered read data, valid the cycle after the access
//   irq_out   pending & mask, zero-extended to 8 bits
module pe_irq_ctrl
  import pe_irq_ctrl_pkg::*;
#(
  parameter int MEMORY_WIDTH = 32,
  parameter int NUM_IRQ      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IRQ-1:0]      irq_in,
  input  logic                    sel_in,
  input  logic [MEMORY_WIDTH-1:0] addr_in,
  input  logic                    wr_in,
  input  logic [MEMORY_WIDTH-1:0] data_in,
  output logic [MEMORY_WIDTH-1:0] data_out,
  output logic [7:0]              irq_out
);

  localparam logic [2:0] OFF_STATUS  = IRQC_STATUS[4:2];
  localparam logic [2:0] OFF_PENDING = IRQC_PENDING[4:2];
  localparam logic [2:0] OFF_MASK    = IRQC_MASK[4:2];
  localparam logic [2:0] OFF_EDGE    = IRQC_EDGE[4:2];
  localparam logic [2:0] OFF_CLAIM   = IRQC_CLAIM[4:2];
  localparam logic [2:0] OFF_LATENCY = IRQC_LATENCY[4:2];

  logic [NUM_IRQ-1:0] mask_r;
  logic [NUM_IRQ-1:0] edge_r;
  logic [NUM_IRQ-1:0] pending_s;
  logic [NUM_IRQ-1:0] status_s;
  logic [NUM_IRQ-1:0] clear_s;
  logic [7:0]         status8_s;
  logic [3:0]         claim_code_s;
  logic [2:0]         offset_s;
  logic               rd_s;
  logic               wr_s;
  logic               claim_hit_s;
  word_t              counter_r;
  word_t              latency_r;
  word_t              data_out_r;
  word_t              rdata_s;
  logic               unused_s;

  assign offset_s = addr_in[4:2];
  assign wr_s     = sel_in & wr_in;
  assign rd_s     = sel_in & ~wr_in;
  assign status_s = pending_s & mask_r;

  // Bus bits outside the decoded window are intentionally dropped.
  assign unused_s = ^{addr_in[MEMORY_WIDTH-1:5], addr_in[1:0],
                      data_in[MEMORY_WIDTH-1:NUM_IRQ], IRQC_BASE[0]};

  // Widen status to the 8-bit CPU vector and pick the claim winner.
  always_comb begin
    status8_s                = 8'h00;
    status8_s[NUM_IRQ-1:0]   = status_s;
    claim_code_s             = irqc_claim_code(status8_s);
    claim_hit_s              = rd_s && (offset_s == OFF_CLAIM) && (claim_code_s != 4'd0);
  end

  // Clear requests: W1C on PENDING or the winner of a successful claim.
  always_comb begin
    clear_s = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (wr_s && (offset_s == OFF_PENDING) && data_in[i]) begin
        clear_s[i] = 1'b1;
      end else if (claim_hit_s && (claim_code_s == 4'(i + 1))) begin
        clear_s[i] = 1'b1;
      end else begin
        clear_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    pe_irq_source u_src (
      .clock     (clock),
      .reset     (reset),
      .irq       (irq_in[g]),
      .edge_mode (edge_r[g]),
      .clear     (clear_s[g]),
      .pending   (pending_s[g])
    );
  end

  // MASK and EDGE registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mask_r <= '0;
      edge_r <= '1;
    end else if (wr_s) begin
      case (offset_s)
        OFF_MASK: mask_r <= data_in[NUM_IRQ-1:0];
        OFF_EDGE: edge_r <= data_in[NUM_IRQ-1:0];
        default: begin
          mask_r <= mask_r;
          edge_r <= edge_r;
        end
      endcase
    end else begin
      mask_r <= mask_r;
      edge_r <= edge_r;
    end
  end

  // Latency counter: runs while anything is unmasked-pending, a nonzero
  // claim snapshots counter + 1 (the claim cycle itself counts).
  always_ff @(posedge clock) begin
    if (!reset) begin
      counter_r <= 32'd0;
      latency_r <= 32'd0;
    end else if (claim_hit_s) begin
      counter_r <= 32'd0;
      latency_r <= irqc_sat_inc(counter_r);
    end else if (status_s != '0) begin
      counter_r <= irqc_sat_inc(counter_r);
      latency_r <= latency_r;
    end else begin
      counter_r <= 32'd0;
      latency_r <= latency_r;
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rdata_s = 32'd0;
    case (offset_s)
      OFF_STATUS:  rdata_s = word_t'(status_s);
      OFF_PENDING: rdata_s = word_t'(pending_s);
      OFF_MASK:    rdata_s = word_t'(mask_r);
      OFF_EDGE:    rdata_s = word_t'(edge_r);
      OFF_CLAIM:   rdata_s = word_t'(claim_code_s);
      OFF_LATENCY: rdata_s = latency_r;
      default:     rdata_s = 32'd0;
    endcase
  end

  // Read data register; holds between reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out_r <= 32'd0;
    end else if (rd_s) begin
      data_out_r <= rdata_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;
  assign irq_out  = status8_s;

endmodule

// File: tb/tb_pe_irq_ctrl.sv
// Self-checking bench for pe_irq_ctrl: a register-access vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// behavioural model of the controller.
module tb_pe_irq_ctrl;

  localparam logic [31:0] BASE    = 32'hF000_0000;
  localparam logic [31:0] R_STAT  = 32'h00;
  localparam logic [31:0] R_PEND  = 32'h04;
  localparam logic [31:0] R_MASK  = 32'h08;
  localparam logic [31:0] R_EDGE  = 32'h0C;
  localparam logic [31:0] R_CLAIM = 32'h10;
  localparam logic [31:0] R_LAT   = 32'h14;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        sel_in;
  logic [31:0] addr_in;
  logic        wr_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  irq_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pe_irq_ctrl #(.MEMORY_WIDTH(32), .NUM_IRQ(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .irq_in   (irq_in),
    .sel_in   (sel_in),
    .addr_in  (addr_in),
    .wr_in    (wr_in),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_out  (irq_out)
  );

  typedef struct {
    logic [3:0]  irq;
    logic        sel;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic        chk_d;
    logic [31:0] exp_d;
    logic [7:0]  exp_irq;
  } vec_t;

  vec_t vecs[18];

  // Behavioural model state (values visible after the most recent edge).
  int unsigned     m_pend, m_mask, m_edge, m_prev, m_dout;
  longint unsigned m_cnt, m_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic w, input logic [31:0] off, input logic [31:0] d);
    sel_in  = s;
    wr_in   = w;
    addr_in = BASE | off;
    data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
    drive(1'b1, 1'b1, off, d);
    step();
    idle();
  endtask

  task automatic read_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    drive(1'b1, 1'b0, off, 32'h0);
    step();
    check(name, data_out, exp);
    idle();
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    irq_in = 4'h0;
    idle();
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic void mdl_reset();
    m_pend = 0; m_mask = 0; m_edge = 32'hF; m_prev = 0; m_dout = 0;
    m_cnt = 0; m_lat = 0;
  endfunction

  // One clock of the controller, from its register-level rules.
  function automatic void mdl_step(input logic [3:0] irq, input logic s, input logic w,
                                   input logic [2:0] idx, input logic [31:0] d);
    int unsigned st, rise, clr, lowbit, win, nxt;
    st     = m_pend & m_mask;
    rise   = 32'(irq) & ~m_prev & 32'hF;
    clr    = 0;
    lowbit = st & (~st + 1);
    win    = $clog2(lowbit);
    if (s && !w) begin
      case (idx)
        3'd0: m_dout = st;
        3'd1: m_dout = m_pend;
        3'd2: m_dout = m_mask;
        3'd3: m_dout = m_edge;
        3'd4: m_dout = (st != 0) ? win + 1 : 0;
        3'd5: m_dout = 32'(m_lat);
        default: m_dout = 0;
      endcase
    end
    if (s && !w && idx == 3'd4 && st != 0) begin
      m_lat = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      m_cnt = 0;
      clr   = clr | lowbit;
    end else if (st != 0) begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
    if (s && w && idx == 3'd1) clr = clr | (d & 32'hF);
    nxt = (m_edge & (rise | (m_pend & ~clr))) | (~m_edge & 32'(irq));
    if (s && w && idx == 3'd2) m_mask = d & 32'hF;
    if (s && w && idx == 3'd3) m_edge = d & 32'hF;
    m_pend = nxt & 32'hF;
    m_prev = 32'(irq);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ri;
    logic        rs, rw;
    logic [2:0]  ridx;
    logic [31:0] rd;

    //            irq   sel   wr    idx   wdata          chk   exp_d          exp_irq
    vecs[0]  = '{4'h0, 1'b1, 1'b0, 3'd2, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[1]  = '{4'h0, 1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[2]  = '{4'h0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[3]  = '{4'h0, 1'b1, 1'b0, 3'd5, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[4]  = '{4'h0, 1'b1, 1'b0, 3'd3, 32'h0,         1'b1, 32'hF,         8'h00};
    vecs[5]  = '{4'h4, 1'b0, 1'b0, 3'd0, 32'h0,         1'b1, 32'hF,         8'h00};
    vecs[6]  = '{4'h0, 1'b1, 1'b0, 3'd1, 32'h0,         1'b1, 32'h4,         8'h00};
    vecs[7]  = '{4'h0, 1'b1, 1'b1, 3'd2, 32'hF,         1'b0, 32'h0,         8'h04};
    vecs[8]  = '{4'h0, 1'b1, 1'b0, 3'd0, 32'h0,         1'b1, 32'h4,         8'h04};
    vecs[9]  = '{4'h0, 1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 32'h3,         8'h00};
    vecs[10] = '{4'h0, 1'b1, 1'b0, 3'd5, 32'h0,         1'b1, 32'h2,         8'h00};
    vecs[11] = '{4'h0, 1'b1, 1'b0, 3'd4, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[12] = '{4'h0, 1'b1, 1'b0, 3'd3, 32'h0,         1'b1, 32'hF,         8'h00};
    vecs[13] = '{4'h0, 1'b1, 1'b0, 3'd7, 32'h0,         1'b1, 32'h0,         8'h00};
    vecs[14] = '{4'h0, 1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 1'b0, 32'h0,         8'h00};
    vecs[15] = '{4'h0, 1'b1, 1'b0, 3'd2, 32'h0,         1'b1, 32'hF,         8'h00};
    vecs[16] = '{4'h0, 1'b1, 1'b1, 3'd2, 32'hFFFF_FFF5, 1'b0, 32'h0,         8'h00};
    vecs[17] = '{4'h0, 1'b1, 1'b0, 3'd2, 32'h0,         1'b1, 32'h5,         8'h00};

    apply_reset();
    check("reset_irq_out", {24'h0, irq_out}, 32'h0);
    check("reset_data_out", data_out, 32'h0);

    // Register table: reset values, masked edge, mask write, claim, latency.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].sel, vecs[i].wr, {27'h0, vecs[i].idx, 2'b00}, vecs[i].wdata);
      irq_in = vecs[i].irq;
      step();
      check($sformatf("vec%0d_irq_out", i), {24'h0, irq_out}, {24'h0, vecs[i].exp_irq});
      if (vecs[i].chk_d) check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_d);
      idle();
    end

    // Back-to-back claims walk the pending set in priority order.
    apply_reset();
    bus_write(R_MASK, 32'hF);
    irq_in = 4'h6;
    step();
    irq_in = 4'h0;
    check("seqA_irq_6", {24'h0, irq_out}, 32'h6);
    read_check("seqA_claim_2", R_CLAIM, 32'h2);
    check("seqA_irq_4", {24'h0, irq_out}, 32'h4);
    read_check("seqA_claim_3", R_CLAIM, 32'h3);
    check("seqA_irq_0", {24'h0, irq_out}, 32'h0);
    read_check("seqA_claim_0", R_CLAIM, 32'h0);

    // Level source survives a claim and follows the line.
    irq_in = 4'h1;
    bus_write(R_EDGE, 32'h0);
    read_check("seqB_pend_1", R_PEND, 32'h1);
    read_check("seqB_claim_1", R_CLAIM, 32'h1);
    check("seqB_irq_after_claim", {24'h0, irq_out}, 32'h1);
    read_check("seqB_pend_kept", R_PEND, 32'h1);
    irq_in = 4'h0;
    step();
    check("seqB_irq_dropped", {24'h0, irq_out}, 32'h0);
    read_check("seqB_pend_0", R_PEND, 32'h0);

    // Claim latency after 10 waiting cycles.
    apply_reset();
    bus_write(R_MASK, 32'h2);
    irq_in = 4'h2;
    step();
    check("seqC_irq_2", {24'h0, irq_out}, 32'h2);
    repeat (10) step();
    read_check("seqC_claim_2", R_CLAIM, 32'h2);
    read_check("seqC_latency_11", R_LAT, 32'd11);

    // New edge beats a same-cycle W1C; a plain W1C clears.
    apply_reset();
    bus_write(R_MASK, 32'hF);
    irq_in = 4'h2;
    step();
    irq_in = 4'h0;
    step();
    irq_in = 4'h2;
    bus_write(R_PEND, 32'h2);
    read_check("seqD_collision_keep", R_PEND, 32'h2);
    bus_write(R_PEND, 32'h2);
    read_check("seqD_w1c_clear", R_PEND, 32'h0);
    check("seqD_irq_0", {24'h0, irq_out}, 32'h0);

    // Reset mid-operation overrides a concurrent write.
    irq_in = 4'h0;
    bus_write(R_MASK, 32'hF);
    irq_in = 4'hF;
    step();
    irq_in = 4'h0;
    step();
    step();
    read_check("seqE_claim_1", R_CLAIM, 32'h1);
    irq_in = 4'h1;
    step();
    irq_in = 4'h0;
    step();
    check("seqE_irq_F", {24'h0, irq_out}, 32'hF);
    reset = 1'b0;
    drive(1'b1, 1'b1, R_MASK, 32'hA);
    step();
    check("seqE_irq_after_reset", {24'h0, irq_out}, 32'h0);
    check("seqE_data_after_reset", data_out, 32'h0);
    reset = 1'b1;
    idle();
    read_check("seqE_mask", R_MASK, 32'h0);
    read_check("seqE_pend", R_PEND, 32'h0);
    read_check("seqE_stat", R_STAT, 32'h0);
    read_check("seqE_edge", R_EDGE, 32'hF);
    read_check("seqE_lat", R_LAT, 32'h0);

    // Randomized run against the model.
    apply_reset();
    mdl_reset();
    for (int c = 0; c < 600; c++) begin
      ri   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq_in;
      rs   = 1'($urandom_range(0, 1));
      rw   = ($urandom_range(0, 3) == 0);
      ridx = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      rd   = $urandom;
      drive(rs, rw, {27'h0, ridx, 2'b00}, rd);
      irq_in = ri;
      step();
      mdl_step(ri, rs, rw, ridx, rd);
      check($sformatf("rnd%0d_irq_out", c), {24'h0, irq_out}, m_pend & m_mask);
      check($sformatf("rnd%0d_data", c), data_out, m_dout);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
